// File: rtl/pipe_mux_pkg.sv
// Shared types and helpers for the pipe_mux_n selector stage.
// Optional out-of-range select checking is enabled by PIPE_MUX_SEL_CHECK_EN.
package pipe_mux_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_mux_state_e;

   // A 2-input mux still needs a 1-bit select, so never return 0.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pipe_mux_n_if.sv
// Upstream word/select handshake and downstream data handshake of pipe_mux_n.
// master = driver of inputs (upstream/downstream agents), slave = the mux stage.
interface pipe_mux_n_if
   import pipe_mux_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4
);
   localparam int SEL_W = clog2_min1(NUM_IN);

   logic [NUM_IN*WIDTH-1:0] data_in;
   logic [SEL_W-1:0]        sel;
   logic                    in_valid;
   logic                    in_ready;
   logic                    flush;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        data_out;
   logic                    sel_err;

   modport master (
      output data_in, sel, in_valid, flush, out_ready,
      input  in_ready, out_valid, data_out, sel_err
   );

   modport slave (
      input  data_in, sel, in_valid, flush, out_ready,
      output in_ready, out_valid, data_out, sel_err
   );
endinterface

// File: rtl/pipe_mux_sel.sv
// Combinational N:1 word selector; out-of-range select gives word 0, or zero
// data plus an oob flag when PIPE_MUX_SEL_CHECK_EN is defined.
module pipe_mux_sel #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2
) (
   input  logic [NUM_IN*WIDTH-1:0] data_in,
   input  logic [SEL_W-1:0]        sel,
`ifdef PIPE_MUX_SEL_CHECK_EN
   output logic                    sel_oob,
`endif
   output logic [WIDTH-1:0]        data_out
);

`ifdef PIPE_MUX_SEL_CHECK_EN
   always_comb begin
      data_out = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) data_out = data_in[k*WIDTH +: WIDTH];
      end
   end

   // With a power-of-2 input count every select value is legal.
   if ((1 << SEL_W) > NUM_IN) begin : g_oob
      assign sel_oob = (sel >= SEL_W'(NUM_IN));
   end else begin : g_no_oob
      assign sel_oob = 1'b0;
   end
`else
   always_comb begin
      data_out = data_in[WIDTH-1:0];
      for (int k = 1; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) data_out = data_in[k*WIDTH +: WIDTH];
      end
   end
`endif

endmodule

// File: rtl/pipe_mux_n.sv
// N:1 selector with registered valid/ready output and 2-entry skid; latency 1 cycle.
// in_ready drops only when the skid is full (no comb path from out_ready); flush wins. Macro: PIPE_MUX_SEL_CHECK_EN.
module pipe_mux_n
   import pipe_mux_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   pipe_mux_n_if.slave bus
);
   localparam int SEL_W = clog2_min1(NUM_IN);

   pipe_mux_state_e  state_q, state_d;
   logic [WIDTH-1:0] main_q, skid_q, sel_word;
   logic             accept, xfer;
   logic             load_main, load_skid, skid_to_main;

   assign bus.out_valid = (state_q != EMPTY);
   assign bus.in_ready  = (state_q != TWO);
   assign bus.data_out  = main_q;
   assign accept        = bus.in_valid & bus.in_ready;
   assign xfer          = bus.out_valid & bus.out_ready;

`ifdef PIPE_MUX_SEL_CHECK_EN
   logic sel_oob, sel_err_q;

   pipe_mux_sel #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_sel (
      .data_in (bus.data_in),
      .sel     (bus.sel),
      .sel_oob (sel_oob),
      .data_out(sel_word)
   );

   // Sticky until reset; a flush does not hide an illegal select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 sel_err_q <= 1'b0;
      else if (accept && sel_oob) sel_err_q <= 1'b1;
   end
   assign bus.sel_err = sel_err_q;
`else
   pipe_mux_sel #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_sel (
      .data_in (bus.data_in),
      .sel     (bus.sel),
      .data_out(sel_word)
   );
   assign bus.sel_err = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      if (bus.flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (accept) begin
               state_d   = ONE;
               load_main = 1'b1;
            end
            ONE: begin
               if (accept && xfer) begin
                  load_main = 1'b1;
               end else if (accept) begin
                  state_d   = TWO;
                  load_skid = 1'b1;
               end else if (xfer) begin
                  state_d = EMPTY;
               end
            end
            TWO: if (xfer) begin
               state_d      = ONE;
               skid_to_main = 1'b1;
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load_main)         main_q <= sel_word;
         else if (skid_to_main) main_q <= skid_q;
         if (load_skid)         skid_q <= sel_word;
      end
   end

endmodule
